// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_pkg
//  Description : Shared CSR addresses, bit indices, cause codes and op helper
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;

    localparam logic [3:0] CAUSE_M_TIMER = 4'd7;
    localparam logic [3:0] CAUSE_M_EXT   = 4'd11;

    typedef enum logic [2:0] {
        CSR_OP_NONE = 3'b000,
        CSR_OP_RW   = 3'b001,
        CSR_OP_RS   = 3'b010,
        CSR_OP_RC   = 3'b011,
        CSR_OP_RWI  = 3'b101,
        CSR_OP_RSI  = 3'b110,
        CSR_OP_RCI  = 3'b111
    } csr_op_e;

    function automatic logic [31:0] csr_apply(input logic [2:0]  f3,
                                              input logic [31:0] old_v,
                                              input logic [31:0] operand);
        case (csr_op_e'(f3))
            CSR_OP_RW, CSR_OP_RWI: return operand;
            CSR_OP_RS, CSR_OP_RSI: return old_v | operand;
            CSR_OP_RC, CSR_OP_RCI: return old_v & ~operand;
            default:               return old_v;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_unit_irq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync
//  Description : NUM_SYNC-stage flop synchroniser for one interrupt line
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int NUM_SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_SYNC-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[NUM_SYNC-2:0], async_in};
        end
    end

    assign sync_out = r_sync[NUM_SYNC-1];

endmodule
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : csr_unit
//  Description : Machine-mode CSR file with timer/external trap and mret redirect
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_unit #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          NUM_SYNC    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    input  logic        csr_reg_wr,
    input  logic        csr_reg_rd,
    input  logic        is_mret,
    input  logic [2:0]  funct3,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] pc_in,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] epc
);

    import csr_pkg::*;

    logic        r_mie;
    logic        r_mpie;
    logic        r_mtie;
    logic        r_meie;
    logic [29:0] r_mtvec_base;
    logic        r_mtvec_mode;
    logic [29:0] r_mepc;
    logic [31:0] r_mcause;

    logic        w_mtip;
    logic        w_meip;
    logic [31:0] w_mstatus;
    logic [31:0] w_mie;
    logic [31:0] w_mip;
    logic [31:0] w_old;
    logic [31:0] w_operand;
    logic [31:0] w_new;
    logic        w_ext_pend;
    logic        w_tim_pend;
    logic        w_trap;
    logic        w_mret;
    logic        w_wr_en;
    logic [3:0]  w_cause;
    logic [31:0] w_base;
    logic        w_unused;

    irq_sync #(.NUM_SYNC(NUM_SYNC)) u_sync_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (timer_irq),
        .sync_out (w_mtip)
    );

    irq_sync #(.NUM_SYNC(NUM_SYNC)) u_sync_ext (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ext_irq),
        .sync_out (w_meip)
    );

    always_comb begin
        w_mstatus               = '0;
        w_mstatus[MSTATUS_MIE]  = r_mie;
        w_mstatus[MSTATUS_MPIE] = r_mpie;
        w_mie                   = '0;
        w_mie[MIE_MTIE]         = r_mtie;
        w_mie[MIE_MEIE]         = r_meie;
        w_mip                   = '0;
        w_mip[MIE_MTIE]         = w_mtip;
        w_mip[MIE_MEIE]         = w_meip;
    end

    always_comb begin
        case (csr_addr)
            CSR_MSTATUS: w_old = w_mstatus;
            CSR_MIE:     w_old = w_mie;
            CSR_MTVEC:   w_old = {r_mtvec_base, 1'b0, r_mtvec_mode};
            CSR_MEPC:    w_old = {r_mepc, 2'b00};
            CSR_MCAUSE:  w_old = r_mcause;
            CSR_MIP:     w_old = w_mip;
            default:     w_old = '0;
        endcase
    end

    assign w_operand = funct3[2] ? {27'd0, rs1_addr} : rs1_data;
    assign w_new     = csr_apply(funct3, w_old, w_operand);

    assign w_ext_pend = r_meie & w_meip;
    assign w_tim_pend = r_mtie & w_mtip;
    assign w_trap     = instr_valid & r_mie & (w_ext_pend | w_tim_pend);
    assign w_cause    = w_ext_pend ? CAUSE_M_EXT : CAUSE_M_TIMER;
    assign w_mret     = instr_valid & is_mret & ~w_trap;

    // Set/clear forms (funct3[1] = 1) with rs1 = x0 are pure reads.
    assign w_wr_en = instr_valid & csr_reg_wr & (funct3[1:0] != 2'b00) & ~w_trap
                   & ~(funct3[1] & (rs1_addr == 5'd0));

    assign w_base    = {r_mtvec_base, 2'b00};
    assign epc_taken = w_trap | w_mret;
    assign epc       = w_trap ? (r_mtvec_mode ? w_base + {26'd0, w_cause, 2'b00} : w_base)
                              : {r_mepc, 2'b00};
    assign csr_rdata = csr_reg_rd ? w_old : '0;

    assign w_unused = ^pc_in[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie        <= 1'b0;
            r_mpie       <= 1'b0;
            r_mtie       <= 1'b0;
            r_meie       <= 1'b0;
            r_mtvec_base <= MTVEC_RESET[31:2];
            r_mtvec_mode <= MTVEC_RESET[0];
            r_mepc       <= '0;
            r_mcause     <= '0;
        end else if (w_trap) begin
            r_mepc   <= pc_in[31:2];
            r_mcause <= {1'b1, 27'd0, w_cause};
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (w_mret) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    r_mie  <= w_new[MSTATUS_MIE];
                    r_mpie <= w_new[MSTATUS_MPIE];
                end
                CSR_MIE: begin
                    r_mtie <= w_new[MIE_MTIE];
                    r_meie <= w_new[MIE_MEIE];
                end
                CSR_MTVEC: begin
                    r_mtvec_base <= w_new[31:2];
                    r_mtvec_mode <= w_new[0];
                end
                CSR_MEPC:   r_mepc   <= w_new[31:2];
                CSR_MCAUSE: r_mcause <= w_new;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_unit
//  Description : Vector table, directed corner sequences and randomized model check
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid, csr_reg_wr, csr_reg_rd, is_mret;
    logic [2:0]  funct3;
    logic [11:0] csr_addr;
    logic [4:0]  rs1_addr;
    logic [31:0] rs1_data, pc_in;
    logic        timer_irq, ext_irq;
    logic [31:0] csr_rdata;
    logic        epc_taken;
    logic [31:0] epc;

    csr_unit #(.MTVEC_RESET(32'h0000_0000), .NUM_SYNC(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .csr_reg_wr  (csr_reg_wr),
        .csr_reg_rd  (csr_reg_rd),
        .is_mret     (is_mret),
        .funct3      (funct3),
        .csr_addr    (csr_addr),
        .rs1_addr    (rs1_addr),
        .rs1_data    (rs1_data),
        .pc_in       (pc_in),
        .timer_irq   (timer_irq),
        .ext_irq     (ext_irq),
        .csr_rdata   (csr_rdata),
        .epc_taken   (epc_taken),
        .epc         (epc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        v, wr, rd, mret;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [4:0]  rs1a;
        logic [31:0] rs1d, pc;
        logic        t, e;
        logic [31:0] exp_rd;
        logic        exp_tk;
        logic [31:0] exp_epc;
    } vec_t;

    function automatic vec_t mk(logic v, logic wr, logic rd, logic mret, logic [2:0] f3,
                                logic [11:0] addr, logic [4:0] rs1a, logic [31:0] rs1d,
                                logic [31:0] pc, logic t, logic e, logic [31:0] exp_rd,
                                logic exp_tk, logic [31:0] exp_epc);
        vec_t x;
        x.v = v; x.wr = wr; x.rd = rd; x.mret = mret; x.f3 = f3; x.addr = addr;
        x.rs1a = rs1a; x.rs1d = rs1d; x.pc = pc; x.t = t; x.e = e;
        x.exp_rd = exp_rd; x.exp_tk = exp_tk; x.exp_epc = exp_epc;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        instr_valid = x.v;   csr_reg_wr = x.wr;  csr_reg_rd = x.rd; is_mret = x.mret;
        funct3      = x.f3;  csr_addr   = x.addr; rs1_addr  = x.rs1a;
        rs1_data    = x.rs1d; pc_in     = x.pc;  timer_irq  = x.t;  ext_irq = x.e;
    endtask

    // Drive one cycle, check outputs at the falling edge, then let the edge commit.
    task automatic run_vec(input vec_t x, input string tag);
        drive(x);
        @(negedge clk);
        check({tag, ".rdata"}, csr_rdata, x.exp_rd);
        check({tag, ".taken"}, {31'd0, epc_taken}, {31'd0, x.exp_tk});
        if (x.exp_tk) check({tag, ".epc"}, epc, x.exp_epc);
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (architectural CSR words) ----------------
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause;
    logic        m_tsync[2], m_esync[2];

    function automatic logic [31:0] m_mip();
        return (m_tsync[1] ? 32'h80 : 32'h0) | (m_esync[1] ? 32'h800 : 32'h0);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip();
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
        m_tsync[0] = 0; m_tsync[1] = 0; m_esync[0] = 0; m_esync[1] = 0;
    endtask

    task automatic rand_cycle(input int i);
        logic [11:0] addrs[7] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h7C0};
        logic [2:0]  ops[7]   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        vec_t x;
        logic [31:0] pend, old_v, opnd, nv, base;
        logic        trap, mret;
        int          cause;
        x.v    = ($urandom % 8) != 0;
        x.mret = ($urandom % 10) == 0;
        x.wr   = !x.mret && (($urandom % 2) == 1);
        x.rd   = ($urandom % 2) == 1;
        x.f3   = ops[$urandom % 7];
        x.addr = addrs[$urandom % 7];
        x.rs1a = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
        x.rs1d = (($urandom % 2) == 1) ? $urandom : ($urandom & 32'h0000_0888);
        x.pc   = $urandom;
        x.t    = (($urandom % 12) == 0) ? !timer_irq : timer_irq;
        x.e    = (($urandom % 12) == 0) ? !ext_irq : ext_irq;

        pend  = m_mie & m_mip() & 32'h880;
        trap  = x.v && m_mstatus[3] && (pend != 0);
        cause = pend[11] ? 11 : 7;
        mret  = x.v && x.mret && !trap;
        base  = m_mtvec & ~32'h3;
        x.exp_tk  = trap || mret;
        x.exp_epc = trap ? (m_mtvec[0] ? base + 4 * cause : base) : m_mepc;
        x.exp_rd  = x.rd ? m_read(x.addr) : 32'h0;
        run_vec(x, $sformatf("rand%0d", i));

        if (trap) begin
            m_mepc    = x.pc & ~32'h3;
            m_mcause  = 32'h8000_0000 | cause;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        end else if (mret) begin
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (x.v && x.wr && x.f3 != 0 && !(x.f3[1] && x.rs1a == 0)) begin
            old_v = m_read(x.addr);
            opnd  = x.f3[2] ? 32'(x.rs1a) : x.rs1d;
            nv = (x.f3[1:0] == 2'b01) ? opnd :
                 (x.f3[1:0] == 2'b10) ? (old_v | opnd) : (old_v & ~opnd);
            case (x.addr)
                12'h300: m_mstatus = nv & 32'h88;
                12'h304: m_mie     = nv & 32'h880;
                12'h305: m_mtvec   = nv & 32'hFFFF_FFFD;
                12'h341: m_mepc    = nv & 32'hFFFF_FFFC;
                12'h342: m_mcause  = nv;
                default: ;
            endcase
        end
        m_tsync[1] = m_tsync[0]; m_tsync[0] = x.t;
        m_esync[1] = m_esync[0]; m_esync[0] = x.e;
    endtask

    vec_t tbl[$];
    vec_t seq[$];
    logic [11:0] all_addr[6] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};

    initial begin
        drive(mk(0,0,0,0,3'd0,12'h0,5'd0,32'h0,32'h0,0,0,32'h0,0,32'h0));
        #2;
        csr_reg_rd = 1'b1;
        foreach (all_addr[k]) begin
            csr_addr = all_addr[k];
            #1;
            check($sformatf("reset_rd_%h", all_addr[k]), csr_rdata, 32'h0);
        end
        check("reset_taken", {31'd0, epc_taken}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        //          v wr rd mr f3    addr     rs1a  rs1d          pc        t e  exp_rd        tk epc
        tbl.push_back(mk(1,0,1,0,3'd0,12'h300,5'd0,32'h0,        32'h10,  0,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd1,12'h305,5'd1,32'h1001,     32'h14,  0,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h305,5'd0,32'h0,        32'h18,  0,0,32'h1001,     0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd1,12'h305,5'd2,32'h1003,     32'h1C,  0,0,32'h1001,     0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h305,5'd0,32'h0,        32'h20,  0,0,32'h1001,     0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd6,12'h300,5'd8,32'h0,        32'h24,  0,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd3,12'h300,5'd0,32'hFFFF_FFFF,32'h28,  0,0,32'h8,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h300,5'd0,32'h0,        32'h2C,  0,0,32'h8,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd1,12'h304,5'd3,32'h80,       32'h30,  0,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd1,12'h305,5'd3,32'h100,      32'h34,  0,0,32'h1001,     0,32'h0));
        tbl.push_back(mk(1,0,0,0,3'd0,12'h0,  5'd0,32'h0,        32'h3C,  1,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,0,0,0,3'd0,12'h0,  5'd0,32'h0,        32'h3C,  1,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,0,1,0,3'd0,12'h344,5'd0,32'h0,        32'h40,  1,0,32'h80,       1,32'h100));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h341,5'd0,32'h0,        32'h44,  1,0,32'h40,       0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h342,5'd0,32'h0,        32'h44,  1,0,32'h8000_0007,0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h300,5'd0,32'h0,        32'h44,  1,0,32'h80,       0,32'h0));
        tbl.push_back(mk(1,0,0,1,3'd0,12'h0,  5'd0,32'h0,        32'h48,  0,0,32'h0,        1,32'h40));
        tbl.push_back(mk(0,0,1,0,3'd0,12'h300,5'd0,32'h0,        32'h4C,  0,0,32'h88,       0,32'h0));
        tbl.push_back(mk(1,0,1,0,3'd0,12'h300,5'd0,32'h0,        32'h4C,  0,0,32'h88,       0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd1,12'h305,5'd1,32'h101,      32'h50,  0,0,32'h100,      0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h304,5'd4,32'h800,      32'h54,  0,0,32'h80,       0,32'h0));
        tbl.push_back(mk(1,0,0,0,3'd0,12'h0,  5'd0,32'h0,        32'h7C,  1,1,32'h0,        0,32'h0));
        tbl.push_back(mk(1,0,0,0,3'd0,12'h0,  5'd0,32'h0,        32'h7C,  1,1,32'h0,        0,32'h0));
        tbl.push_back(mk(1,0,0,0,3'd0,12'h0,  5'd0,32'h0,        32'h80,  1,1,32'h0,        1,32'h12C));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h342,5'd0,32'h0,        32'h84,  1,1,32'h8000_000B,0,32'h0));
        tbl.push_back(mk(1,0,0,1,3'd0,12'h0,  5'd0,32'h0,        32'h84,  0,0,32'h0,        1,32'h80));
        tbl.push_back(mk(0,0,1,0,3'd0,12'h341,5'd0,32'h0,        32'h88,  0,0,32'h80,       0,32'h0));
        tbl.push_back(mk(1,0,1,0,3'd0,12'h300,5'd0,32'h0,        32'h88,  0,0,32'h88,       0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd1,12'h7C0,5'd1,32'hFFFF_FFFF,32'h8C,  0,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h7C0,5'd0,32'h0,        32'h90,  0,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd1,12'h344,5'd1,32'hFFFF_FFFF,32'h94,  0,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h344,5'd0,32'h0,        32'h98,  0,0,32'h0,        0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd1,12'h342,5'd1,32'hDEAD_BEEF,32'h9C,  0,0,32'h8000_000B,0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h342,5'd0,32'h0,        32'hA0,  0,0,32'hDEAD_BEEF,0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd1,12'h341,5'd1,32'h123,      32'hA4,  0,0,32'h80,       0,32'h0));
        tbl.push_back(mk(1,1,1,0,3'd2,12'h341,5'd0,32'h0,        32'hA8,  0,0,32'h120,      0,32'h0));
        foreach (tbl[k]) run_vec(tbl[k], $sformatf("vec%0d", k));

        // Pending external irq: flush cycles, trap beating a CSR write and mret, MIE set by write.
        seq.push_back(mk(0,0,0,0,3'd0,12'h0,  5'd0,32'h0,32'h1F0,0,1,32'h0,  0,32'h0));
        seq.push_back(mk(0,0,0,0,3'd0,12'h0,  5'd0,32'h0,32'h1F4,0,1,32'h0,  0,32'h0));
        seq.push_back(mk(0,1,1,0,3'd1,12'h304,5'd5,32'h0,32'h1F8,0,1,32'h880,0,32'h0));
        seq.push_back(mk(1,1,1,0,3'd1,12'h304,5'd5,32'h0,32'h200,0,1,32'h880,1,32'h12C));
        seq.push_back(mk(1,1,1,0,3'd2,12'h304,5'd0,32'h0,32'h204,0,1,32'h880,0,32'h0));
        seq.push_back(mk(1,1,1,0,3'd2,12'h341,5'd0,32'h0,32'h208,0,1,32'h200,0,32'h0));
        seq.push_back(mk(1,0,0,1,3'd0,12'h0,  5'd0,32'h0,32'h300,0,1,32'h0,  1,32'h200));
        seq.push_back(mk(1,0,0,1,3'd0,12'h0,  5'd0,32'h0,32'h304,0,1,32'h0,  1,32'h12C));
        seq.push_back(mk(1,1,1,0,3'd2,12'h341,5'd0,32'h0,32'h308,0,1,32'h304,0,32'h0));
        seq.push_back(mk(1,1,1,0,3'd6,12'h300,5'd8,32'h0,32'h30C,0,1,32'h80, 0,32'h0));
        seq.push_back(mk(1,0,0,0,3'd0,12'h0,  5'd0,32'h0,32'h310,0,1,32'h0,  1,32'h12C));
        seq.push_back(mk(1,0,0,1,3'd0,12'h0,  5'd0,32'h0,32'h314,0,1,32'h0,  1,32'h310));
        foreach (seq[k]) run_vec(seq[k], $sformatf("seq%0d", k));

        // Reset asserted while a trap is being signalled.
        drive(mk(1,0,1,0,3'd0,12'h300,5'd0,32'h0,32'h400,0,1,32'h0,0,32'h0));
        #2;
        check("pre_reset_taken", {31'd0, epc_taken}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("midtrap_reset_taken", {31'd0, epc_taken}, 32'h0);
        foreach (all_addr[k]) begin
            csr_addr = all_addr[k];
            #1;
            check($sformatf("midtrap_reset_rd_%h", all_addr[k]), csr_rdata, 32'h0);
        end
        ext_irq = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        model_reset();
        timer_irq = 1'b0;
        for (int i = 0; i < 600; i++) rand_cycle(i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
